riscv_dmem_responder: RTL and testbench
=======================================

# riscv_dmem_responder

Memory-side responder for the data-cache refill/write-back handshake. It accepts one block-sized read (allocate) or write (write-back) request from the cache controller on `mem_rden`/`mem_wren`. It models a fixed access latency followed by a one-word-per-cycle burst into or out of a word-organised backing store, then returns a single-cycle `mem_ready`. It sits between the data-cache controller and the backing memory, and serves as both the synthesizable on-chip main memory and the cache bench's memory model.

## Interface
- `WORD_W`, 32, width of one backing-store word
- `BLOCK_BITS`, 128, cache block width; must be a multiple of `WORD_W`
- `WORDS` (derived), `BLOCK_BITS/WORD_W` = 4; must be a power of two
- `MEM_DEPTH_WORDS`, 1024, backing-store depth in words; power of two, ≥ `WORDS`
- `LATENCY`, 4, wait cycles before the first burst beat; must be ≥ 1
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `mem_rden`  in  1  block read request (allocate); level, held by the requester until `mem_ready`
- `mem_wren`  in  1  block write request (write-back); level, held until `mem_ready`
- `mem_addr`  in  32  byte address; the block-offset bits `[log2(BLOCK_BITS/8)-1:0]` are ignored
- `mem_wdata`  in  `BLOCK_BITS`  write-back block; word i is `[i*WORD_W +: WORD_W]`
- `mem_rdata`  out  `BLOCK_BITS`  read block, registered; same word order as `mem_wdata`
- `mem_ready`  out  1  one-cycle completion pulse, for reads and writes
- `busy`  out  1  high in every state except IDLE

## Operation
- **States:**
  - **IDLE**, the reset state.
  - **WAIT:** latency counter loaded with `LATENCY-1` and decremented each cycle.
  - **BURST:** beat counter runs from 0 to `WORDS-1`.
  - **RESPOND**
- **IDLE:**
  - If `mem_rden | mem_wren` is high at a rising edge, capture the request into registers: op, block base word index, and `mem_wdata` (write only). Then go to WAIT.
  - If both `mem_rden` and `mem_wren` are high, the write wins and the read is dropped.
- **WAIT:** when the counter reaches 0, go to BURST.
- **BURST:** each cycle handles beat b.
  - Word address = (base + b) mod `MEM_DEPTH_WORDS`.
  - Write: the array writes captured word b.
  - Read: array word b, read asynchronously, is loaded into `mem_rdata` word b.
  - After beat `WORDS-1`, go to RESPOND.
- **RESPOND:** `mem_ready` = 1 for this one cycle, then go to IDLE unconditionally.
- **Base word index:** `mem_addr >> log2(WORD_W/8)` with the low `log2(WORDS)` bits cleared, taken mod `MEM_DEPTH_WORDS`. Addresses beyond the depth alias (wrap).
- **Request stability:** inputs are ignored outside IDLE. A request that changes or drops after capture does not affect the transaction in flight.
- **`mem_rdata` hold:**
  - `mem_rdata` holds the last completed read block until the next read's burst overwrites it.
  - Writes do not change `mem_rdata`.
  - During a read burst, partial updates to `mem_rdata` are visible; the value is only defined as the full block in the `mem_ready` cycle.
- **Reset values:** `mem_ready`=0, `busy`=0, `mem_rdata`=0, state IDLE, counters 0.
- **Backing array:**
  - Not reset. Contents are undefined at power-up and preserved across `rst`.
  - Reset mid-transaction aborts it: beats of a write that were already committed stay in the array, no `mem_ready` is produced, and the block returns to IDLE.

## Timing
- Request visible in cycle 0 (IDLE):
  - WAIT occupies cycles 1..`LATENCY`.
  - BURST occupies the next `WORDS` cycles.
  - `mem_ready` is high in cycle `1+LATENCY+WORDS` (cycle 9 at defaults).
- Next request accepted at the earliest in cycle `2+LATENCY+WORDS` (cycle 10), the IDLE cycle after RESPOND.
- Write-back followed by allocate: the cache raises `mem_rden` in the cycle after `mem_ready`, and the read is accepted with no bubble beyond that IDLE cycle.
- A write in cycle N followed by a read of the same block returns the newly written data.

## Structure
- **Package `riscv_mem_pkg`:**
  - responder state enum (IDLE, WAIT, BURST, RESPOND)
  - default `WORD_W`/`BLOCK_BITS` constants
  - request-op enum (RD, WR)
- **Sub-module `riscv_mem_word_array`:** `WORD_W` × `MEM_DEPTH_WORDS`, asynchronous read, synchronous write, single port.
- Elaboration-time assertions on all parameter constraints.

## Test plan
- **Reset:** assert `rst` while a request is pending -> `mem_ready`=0, `busy`=0, `mem_rdata`=0; after release, `busy` rises the cycle after the request is sampled.
- **Write then read:**
  - Write addr 0x40 with data {0x44444444, 0x33333333, 0x22222222, 0x11111111} (word3..word0) -> `mem_ready` only in cycle 9, one cycle wide.
  - Then read 0x40 -> `mem_ready` in cycle 9 of that transaction, with `mem_rdata` equal to the written block.
- **Write-back then allocate:** `mem_wren` on 0x40 until ready, then `mem_rden` on 0x80 from the next cycle -> read accepted in cycle 10, `mem_ready` in cycle 19, `mem_rdata` = the 0x80 contents.
- **Address handling:**
  - Read 0x4C -> same block as 0x40.
  - Read 0x1040 (depth 1024 words) -> aliases 0x40.
- **Reset mid-burst:** pulse `rst` after 2 write beats of 0xAAAA… over block 0x40 -> no `mem_ready`; a later read of 0x40 returns words 0–1 = 0xAAAAAAAA and words 2–3 = the old values.
- **Simultaneous and late-changing requests:**
  - `mem_rden` and `mem_wren` both high -> write performed; `mem_rdata` unchanged.
  - `mem_addr`/`mem_wdata` changed during WAIT -> the captured values are used.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and default geometry for the data-memory responder.
package riscv_mem_pkg;

    // Default backing-store word width and cache block width.
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_BLOCK_BITS = 128;

    // Responder FSM states.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_BURST   = 2'd2,
        S_RESPOND = 2'd3
    } resp_state_e;

    // Captured request operation.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } req_op_e;

endpackage

// File: rtl/riscv_mem_word_array.sv
// Single-port word-organised backing store: asynchronous read, synchronous
// write. Contents are deliberately not reset so they survive rst.
module riscv_mem_word_array #(
    parameter int WORD_W          = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int AW              = $clog2(MEM_DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_array [MEM_DEPTH_WORDS];

    // Commit one word per cycle when the responder is in a write beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[addr] <= wdata;
        end
    end

    assign rdata = mem_array[addr];

endmodule

// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for data-cache refill / write-back. Captures one
// block request in IDLE, waits LATENCY cycles, bursts one word per cycle
// into or out of the backing store, then pulses mem_ready for one cycle.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int WORD_W          = DEF_WORD_W,
    parameter int BLOCK_BITS      = DEF_BLOCK_BITS,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int LATENCY         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_rden,
    input  logic                  mem_wren,
    input  logic [31:0]           mem_addr,
    input  logic [BLOCK_BITS-1:0] mem_wdata,
    output logic [BLOCK_BITS-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  busy
);

    localparam int WORDS    = BLOCK_BITS / WORD_W;
    localparam int AW       = $clog2(MEM_DEPTH_WORDS);
    localparam int BW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BYTE_OFF = $clog2(WORD_W / 8);

    // Parameter sanity checks, evaluated at elaboration.
    if (BLOCK_BITS % WORD_W != 0) begin : g_chk_block_multiple
        $error("BLOCK_BITS must be a multiple of WORD_W");
    end
    if ((WORDS & (WORDS - 1)) != 0) begin : g_chk_words_pow2
        $error("BLOCK_BITS/WORD_W must be a power of two");
    end
    if ((MEM_DEPTH_WORDS & (MEM_DEPTH_WORDS - 1)) != 0) begin : g_chk_depth_pow2
        $error("MEM_DEPTH_WORDS must be a power of two");
    end
    if (MEM_DEPTH_WORDS < WORDS) begin : g_chk_depth_min
        $error("MEM_DEPTH_WORDS must be at least one block");
    end
    if (LATENCY < 1) begin : g_chk_latency
        $error("LATENCY must be at least 1");
    end

    resp_state_e                   state_reg, state_next;
    req_op_e                       op_reg, op_next;
    logic [LW-1:0]                 lat_reg, lat_next;
    logic [BW-1:0]                 beat_reg, beat_next;
    logic [AW-1:0]                 base_reg, base_next;
    logic [WORDS-1:0][WORD_W-1:0]  wdata_reg, wdata_next;
    logic [WORDS-1:0][WORD_W-1:0]  rdata_reg;

    logic [AW-1:0]     req_base;
    logic [AW-1:0]     arr_addr;
    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;
    logic              rd_beat;

    // Block base word index: byte address to word index, block-aligned,
    // then wrapped into the array depth (upper bits alias).
    assign req_base = AW'((mem_addr >> BYTE_OFF) & ~32'(WORDS - 1));

    // Base is block-aligned, so base + beat never carries past the block.
    assign arr_addr = base_reg + AW'(beat_reg);
    assign arr_we   = (state_reg == S_BURST) && (op_reg == OP_WR);
    assign rd_beat  = (state_reg == S_BURST) && (op_reg == OP_RD);

    riscv_mem_word_array #(
        .WORD_W          (WORD_W),
        .MEM_DEPTH_WORDS (MEM_DEPTH_WORDS),
        .AW              (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_reg[beat_reg]),
        .rdata (arr_rdata)
    );

    // Next-state logic: request capture, latency countdown, beat sequencing.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        lat_next   = lat_reg;
        beat_next  = beat_reg;
        base_next  = base_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            S_IDLE: begin
                if (mem_rden || mem_wren) begin
                    // A simultaneous read is dropped in favour of the write.
                    op_next    = mem_wren ? OP_WR : OP_RD;
                    base_next  = req_base;
                    if (mem_wren) begin
                        wdata_next = mem_wdata;
                    end
                    lat_next   = LW'(LATENCY - 1);
                    beat_next  = '0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_reg == '0) begin
                    beat_next  = '0;
                    state_next = S_BURST;
                end else begin
                    lat_next = lat_reg - 1'b1;
                end
            end
            S_BURST: begin
                if (beat_reg == BW'(WORDS - 1)) begin
                    state_next = S_RESPOND;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            S_RESPOND: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control and captured-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_RD;
            lat_reg   <= '0;
            beat_reg  <= '0;
            base_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            lat_reg   <= lat_next;
            beat_reg  <= beat_next;
            base_reg  <= base_next;
            wdata_reg <= wdata_next;
        end
    end

    // Read block assembly: each word lane loads only on its own read beat,
    // so the last completed read is held through writes and idle time.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_rdata
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_reg[gi] <= '0;
            end else if (rd_beat && (beat_reg == BW'(gi))) begin
                rdata_reg[gi] <= arr_rdata;
            end
        end
    end

    assign mem_rdata = rdata_reg;
    assign mem_ready = (state_reg == S_RESPOND);
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder at default parameters.
module tb_riscv_dmem_responder;

    logic         clk;
    logic         rst;
    logic         mem_rden;
    logic         mem_wren;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] BLK_A  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] BLK_B  = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
    localparam logic [127:0] BLK_C  = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
    localparam logic [127:0] BLK_D  = {32'hD0D0D0D3, 32'hD0D0D0D2, 32'hD0D0D0D1, 32'hD0D0D0D0};
    localparam logic [127:0] BLK_AA = {128{1'b1}} & {4{32'hAAAAAAAA}};
    localparam logic [127:0] BLK_AP = {32'h44444444, 32'h33333333, 32'hAAAAAAAA, 32'hAAAAAAAA};

    riscv_dmem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rden  (mem_rden),
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request from cycle 0, holds it until mem_ready, then drops it.
    // Returns the cycle number in which mem_ready was seen (999 on timeout).
    // If alter_cyc > 0, the address/data are changed in that cycle.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [127:0] wd,
                           input int alter_cyc, output int cyc);
        mem_rden  = rd;
        mem_wren  = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == alter_cyc) begin
                mem_addr  = 32'h0000_0040;
                mem_wdata = {4{32'hDEADBEEF}};
            end
            if (mem_ready) break;
        end
        if (!mem_ready) cyc = 999;
        mem_rden = 1'b0;
        mem_wren = 1'b0;
        $display("txn %s rd=%0b wr=%0b addr=%h ready_cycle=%0d rdata=%h",
                 tag, rd, wr, addr, cyc, mem_rdata);
    endtask

    // Steps into the IDLE cycle after RESPOND and checks the pulse ended.
    task automatic after_ready(input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, "_ready_off"}, {127'd0, mem_ready}, 128'd0);
        check_eq({tag, "_idle"}, {127'd0, busy}, 128'd0);
    endtask

    initial begin
        int cyc;
        int cyc2;
        int pulses;

        rst       = 1'b1;
        mem_rden  = 1'b1;
        mem_wren  = 1'b0;
        mem_addr  = 32'h0000_0040;
        mem_wdata = '0;

        // Reset held with a request pending.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {127'd0, mem_ready}, 128'd0);
        check_eq("rst_busy", {127'd0, busy}, 128'd0);
        check_eq("rst_rdata", mem_rdata, 128'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_busy0", {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        check_eq("rel_busy1", {127'd0, busy}, 128'd1);
        cyc = 1;
        while (!mem_ready && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        mem_rden = 1'b0;
        check_eq("rel_ready_cyc", 128'(cyc), 128'd9);
        $display("txn reset_release addr=00000040 ready_cycle=%0d", cyc);
        after_ready("rel");

        // Seed block 0x80.
        run_txn("wr80", 1'b0, 1'b1, 32'h80, BLK_B, 0, cyc);
        check_eq("wr80_cyc", 128'(cyc), 128'd9);
        after_ready("wr80");

        // Write then read 0x40.
        run_txn("wr40", 1'b0, 1'b1, 32'h40, BLK_A, 0, cyc);
        check_eq("wr40_cyc", 128'(cyc), 128'd9);
        after_ready("wr40");
        run_txn("rd40", 1'b1, 1'b0, 32'h40, '0, 0, cyc);
        check_eq("rd40_cyc", 128'(cyc), 128'd9);
        check_eq("rd40_data", mem_rdata, BLK_A);
        after_ready("rd40");

        // Write-back followed by allocate with no extra bubble.
        run_txn("wb40", 1'b0, 1'b1, 32'h40, BLK_A, 0, cyc);
        check_eq("wb40_cyc", 128'(cyc), 128'd9);
        @(posedge clk);
        #1;
        check_eq("wb_ready_off", {127'd0, mem_ready}, 128'd0);
        run_txn("alloc80", 1'b1, 1'b0, 32'h80, '0, 0, cyc2);
        check_eq("alloc_ready_cyc", 128'(cyc + 1 + cyc2), 128'd19);
        check_eq("alloc_data", mem_rdata, BLK_B);
        after_ready("alloc");

        // Offset bits ignored; addresses beyond depth alias.
        run_txn("rd4c", 1'b1, 1'b0, 32'h4C, '0, 0, cyc);
        check_eq("rd4c_data", mem_rdata, BLK_A);
        after_ready("rd4c");
        run_txn("rd1040", 1'b1, 1'b0, 32'h1040, '0, 0, cyc);
        check_eq("rd1040_cyc", 128'(cyc), 128'd9);
        check_eq("rd1040_data", mem_rdata, BLK_A);
        after_ready("rd1040");

        // Simultaneous read and write: write wins, rdata untouched.
        run_txn("both80", 1'b1, 1'b1, 32'h80, BLK_C, 0, cyc);
        check_eq("both_cyc", 128'(cyc), 128'd9);
        check_eq("both_rdata_hold", mem_rdata, BLK_A);
        after_ready("both");
        run_txn("rd80", 1'b1, 1'b0, 32'h80, '0, 0, cyc);
        check_eq("both_written", mem_rdata, BLK_C);
        after_ready("rd80");

        // Address and data changed during WAIT: captured values used.
        run_txn("late_c0", 1'b0, 1'b1, 32'hC0, BLK_D, 2, cyc);
        check_eq("late_cyc", 128'(cyc), 128'd9);
        after_ready("late");
        run_txn("rdc0", 1'b1, 1'b0, 32'hC0, '0, 0, cyc);
        check_eq("late_captured", mem_rdata, BLK_D);
        after_ready("rdc0");
        run_txn("rd40b", 1'b1, 1'b0, 32'h40, '0, 0, cyc);
        check_eq("late_untouched", mem_rdata, BLK_A);
        after_ready("rd40b");

        // Reset after two committed write beats.
        mem_wren  = 1'b1;
        mem_addr  = 32'h40;
        mem_wdata = BLK_AA;
        repeat (7) @(posedge clk);
        #1;
        check_eq("mid_no_ready", {127'd0, mem_ready}, 128'd0);
        rst = 1'b1;
        #1;
        check_eq("mid_busy", {127'd0, busy}, 128'd0);
        check_eq("mid_rdata", mem_rdata, 128'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_wren = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) pulses++;
        end
        check_eq("mid_pulses", 128'(pulses), 128'd0);
        $display("txn reset_mid_burst addr=00000040 ready_pulses=%0d", pulses);
        run_txn("rd40c", 1'b1, 1'b0, 32'h40, '0, 0, cyc);
        check_eq("mid_partial", mem_rdata, BLK_AP);
        after_ready("rd40c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
